id_ex_fwd_stage: RTL and testbench
==================================

Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the pipelined CPU, combined with the operand forwarding and load-use hazard logic for the EX stage.
- Captures decoded operands and control from ID each cycle.
- Generates the two-bit select pairs that drive the EX-stage 3-to-1 operand muxes for operands A and B.
- Asserts stall back to IF/ID on a load-use hazard and inserts a bubble.

Parameters:
- DATA_W, 32, operand/immediate width.
- REG_AW, 6, register index width; index 0 is the hardwired zero register.
- CTRL_W, 8, opaque EX/MEM/WB control bundle width, passed through.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  REG_AW  destination index
- id_reg_write  in  1  writes rd
- id_mem_read  in  1  instruction is a load
- id_rs1_data, id_rs2_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  immediate
- id_ctrl  in  CTRL_W  control bundle
- flush  in  1  kill the instruction in ID (branch taken)
- exm_rd  in  REG_AW  EX/MEM destination
- exm_reg_write  in  1  EX/MEM writes rd
- wb_rd  in  REG_AW  MEM/WB destination
- wb_reg_write  in  1  MEM/WB writes rd
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered
- ex_rd  out  REG_AW  registered
- ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W  registered
- ex_ctrl  out  CTRL_W  registered
- fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2  out  1  mux selects
- stall  out  1  hold PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: asynchronous, active-high. All ex_* outputs, internal ex_rs1/ex_rs2 fields and bubble_cnt go to 0 immediately. With those at 0, stall and all select outputs are also 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Stall (combinational):
  - Asserted when id_valid & !flush & ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0.
  - And additionally ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Register update each clk edge:
  - Priority order: flush, then stall, then normal load.
  - flush or stall: load a bubble (ex_valid, ex_reg_write, ex_mem_read, ex_ctrl all 0; data fields don't care, implementation loads 0).
  - Otherwise: load all ID fields. ex_valid=id_valid; reg_write/mem_read/ctrl are masked to 0 when id_valid=0.
- bubble_cnt: increments by 1 on each edge where stall=1 and flush=0. Saturates at all-ones with no wrap.
- Forwarding uses the registered source indices ex_rs1/ex_rs2, which are held internally with their uses flags. Select encoding {sel1,sel2}:
  - 00 = register file data
  - 01 = EX/MEM result
  - 10 = MEM/WB result
  - 11 is never driven.
- Forwarding rule for operand A (operand B is identical with rs2):
  - If ex_valid & uses_rs1 & exm_reg_write & exm_rd!=0 & exm_rd==ex_rs1: 01.
  - Else if ex_valid & uses_rs1 & wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1: 10.
  - Else: 00.
- EX/MEM takes priority over MEM/WB when both match (newest value wins).
- Index 0 is never forwarded and never causes a stall.
- A bubble in EX (ex_valid=0) forces both select pairs to 00.
- Simultaneous flush and stall: flush wins, stall output is 0 and no count is taken.
- Reset mid-stall: stall drops the same instant, because ex_valid clears asynchronously.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_REG=2'b00, FWD_EXM=2'b01, FWD_WB=2'b10
  - REG_AW and DATA_W defaults
  - the zero register index constant
- One natural sub-module, fwd_sel_unit: purely combinational per-operand select logic, instantiated twice (A and B).

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 → all ex_* = 0, stall = 0, selects = 00, bubble_cnt = 0 without waiting for clk.
- EX/MEM forward: EX holds add with rs1=5; exm_rd=5, exm_reg_write=1; wb_rd=5, wb_reg_write=1 → fwd_a = 01 (EX/MEM priority), fwd_b = 00.
- MEM/WB forward and zero register:
  - ex_rs2=7, wb_rd=7, wb_reg_write=1, exm_rd=3 → fwd_b = 10.
  - Repeat with index 0 → fwd_b = 00.
- Load-use stall: EX holds load rd=9; ID reads rs2=9 with uses_rs2=1 → stall=1. Next cycle ex_valid=0, bubble_cnt=1, and ID contents reach EX one cycle later with stall=0.
- Flush vs stall: same as the load-use case plus flush=1 → stall=0, bubble loaded, bubble_cnt unchanged.
- Counter saturation: CNT_W=2, force 5 consecutive stalls → bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared forwarding select codes, width defaults and the zero register index.
package cpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 6;
  localparam int ZERO_REG = 0;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EXM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: per-operand forwarding select; the newest producer (EX/MEM) wins over MEM/WB.
module fwd_sel_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              i_ex_valid,
  input  logic              i_uses,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic              i_exm_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  output fwd_sel_e          o_sel
);
  logic w_live;
  assign w_live = i_ex_valid & i_uses & (i_rs != REG_AW'(ZERO_REG));
  assign o_sel = (w_live & i_exm_we & (i_exm_rd == i_rs)) ? FWD_EXM :
                 (w_live & i_wb_we & (i_wb_rd == i_rs))   ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: ID/EX pipeline register with EX operand forwarding selects and load-use stall.
module id_ex_fwd_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              fwd_a_sel1,
  output logic              fwd_a_sel2,
  output logic              fwd_b_sel1,
  output logic              fwd_b_sel2,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic              r_valid, r_reg_write, r_mem_read, r_uses_rs1, r_uses_rs2;
  logic [REG_AW-1:0] r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0] r_rs1_data, r_rs2_data, r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_stall;
  fwd_sel_e          w_sel_a, w_sel_b;

  // r_rd is never the zero register when it matches here, so index 0 cannot stall
  assign w_stall = id_valid & ~flush & r_valid & r_mem_read & r_reg_write &
                   (r_rd != REG_AW'(ZERO_REG)) &
                   ((id_uses_rs1 & (id_rs1 == r_rd)) | (id_uses_rs2 & (id_rs2 == r_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || w_stall) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_uses_rs1  <= 1'b0;
      r_uses_rs2  <= 1'b0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_ctrl      <= '0;
    end else begin
      r_valid     <= id_valid;
      r_reg_write <= id_valid & id_reg_write;
      r_mem_read  <= id_valid & id_mem_read;
      r_uses_rs1  <= id_uses_rs1;
      r_uses_rs2  <= id_uses_rs2;
      r_rd        <= id_rd;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_ex_valid(r_valid), .i_uses(r_uses_rs1), .i_rs(r_rs1),
    .i_exm_rd(exm_rd), .i_exm_we(exm_reg_write),
    .i_wb_rd(wb_rd), .i_wb_we(wb_reg_write), .o_sel(w_sel_a)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_ex_valid(r_valid), .i_uses(r_uses_rs2), .i_rs(r_rs2),
    .i_exm_rd(exm_rd), .i_exm_we(exm_reg_write),
    .i_wb_rd(wb_rd), .i_wb_we(wb_reg_write), .o_sel(w_sel_b)
  );

  assign {fwd_a_sel1, fwd_a_sel2} = w_sel_a;
  assign {fwd_b_sel1, fwd_b_sel2} = w_sel_b;
  assign stall        = w_stall;
  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_rd        = r_rd;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_imm       = r_imm;
  assign ex_ctrl      = r_ctrl;
  assign bubble_cnt   = r_cnt;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb_id_ex_fwd_stage: directed table, random stimulus vs. reference model, reset and saturation sequences.
module tb_id_ex_fwd_stage;
  typedef struct packed {
    logic       valid;
    logic [5:0] rs1, rs2;
    logic       u1, u2;
    logic [5:0] rd;
    logic       rw, mr;
    logic [31:0] d1, d2, imm;
    logic [7:0] ctrl;
    logic       flush;
    logic [5:0] exm_rd;
    logic       exm_we;
    logic [5:0] wb_rd;
    logic       wb_we;
  } in_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] rd, rs1, rs2;
    logic       u1, u2, rw, mr;
    logic [31:0] d1, d2, imm;
    logic [7:0] ctrl;
  } ex_t;

  typedef struct {
    in_t        inp;
    logic       stall;
    logic [1:0] a, b;
  } vec_t;

  logic clk = 0, rst = 1;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic [5:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, exm_rd = 0, wb_rd = 0;
  logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [7:0] id_ctrl = 0;
  logic flush = 0, exm_reg_write = 0, wb_reg_write = 0;
  logic ex_valid, ex_reg_write, ex_mem_read, stall;
  logic [5:0] ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [7:0] ex_ctrl;
  logic fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2;
  logic [15:0] bubble_cnt;
  logic s_valid, s_reg_write, s_mem_read, s_stall;
  logic [5:0] s_rd;
  logic [31:0] s_rs1_data, s_rs2_data, s_imm;
  logic [7:0] s_ctrl;
  logic s_a1, s_a2, s_b1, s_b2;
  logic [1:0] s_cnt;

  int nvec = 0, nerr = 0;
  ex_t m;
  int cnt16, cnt2;
  in_t cur;
  vec_t tbl[9];
  int sat_exp[5];

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .fwd_a_sel1(fwd_a_sel1), .fwd_a_sel2(fwd_a_sel2), .fwd_b_sel1(fwd_b_sel1),
    .fwd_b_sel2(fwd_b_sel2), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_fwd_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read), .ex_rd(s_rd),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_ctrl(s_ctrl),
    .fwd_a_sel1(s_a1), .fwd_a_sel2(s_a2), .fwd_b_sel1(s_b1),
    .fwd_b_sel2(s_b2), .stall(s_stall), .bubble_cnt(s_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                             input logic u2, input int rd, input logic rw, input logic mr,
                             input logic fl, input int xr, input logic xw, input int wr,
                             input logic ww);
    in_t i;
    i.valid = v; i.rs1 = 6'(rs1); i.rs2 = 6'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = 6'(rd); i.rw = rw; i.mr = mr; i.flush = fl;
    i.exm_rd = 6'(xr); i.exm_we = xw; i.wb_rd = 6'(wr); i.wb_we = ww;
    i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom; i.ctrl = 8'($urandom);
    return i;
  endfunction

  // Reference: stall and selects straight from the hazard rules, EX contents as a record.
  function automatic logic m_stall(input in_t i);
    logic dep = (i.u1 && i.rs1 == m.rd) || (i.u2 && i.rs2 == m.rd);
    return i.valid && !i.flush && m.valid && m.mr && m.rw && m.rd != 0 && dep;
  endfunction

  function automatic logic [1:0] m_sel(input logic u, input logic [5:0] rs, input in_t i);
    if (!m.valid || !u || rs == 0) return 2'b00;
    if (i.exm_we && i.exm_rd == rs) return 2'b01;
    if (i.wb_we && i.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(input in_t i);
    cur = i;
    id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr; id_rs1_data = i.d1;
    id_rs2_data = i.d2; id_imm = i.imm; id_ctrl = i.ctrl; flush = i.flush;
    exm_rd = i.exm_rd; exm_reg_write = i.exm_we; wb_rd = i.wb_rd; wb_reg_write = i.wb_we;
    #2;
  endtask

  task automatic check_comb();
    chk("stall", 64'(stall), 64'(m_stall(cur)));
    chk("fwd_a", 64'({fwd_a_sel1, fwd_a_sel2}), 64'(m_sel(m.u1, m.rs1, cur)));
    chk("fwd_b", 64'({fwd_b_sel1, fwd_b_sel2}), 64'(m_sel(m.u2, m.rs2, cur)));
  endtask

  task automatic check_regs();
    chk("ex_valid", 64'(ex_valid), 64'(m.valid));
    chk("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
    chk("ex_mem_read", 64'(ex_mem_read), 64'(m.mr));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(cnt16));
    chk("bubble_cnt_w2", 64'(s_cnt), 64'(cnt2));
    if (m.valid) begin
      chk("ex_rd", 64'(ex_rd), 64'(m.rd));
      chk("ex_rs1_data", 64'(ex_rs1_data), 64'(m.d1));
      chk("ex_rs2_data", 64'(ex_rs2_data), 64'(m.d2));
      chk("ex_imm", 64'(ex_imm), 64'(m.imm));
    end
  endtask

  task automatic edge_step();
    logic s = m_stall(cur);
    @(posedge clk);
    if (cur.flush || s) m = '0;
    else begin
      m.valid = cur.valid; m.rd = cur.rd; m.rs1 = cur.rs1; m.rs2 = cur.rs2;
      m.u1 = cur.u1; m.u2 = cur.u2; m.rw = cur.valid && cur.rw; m.mr = cur.valid && cur.mr;
      m.d1 = cur.d1; m.d2 = cur.d2; m.imm = cur.imm; m.ctrl = cur.valid ? cur.ctrl : 8'h0;
    end
    if (s) begin
      cnt16 = (cnt16 == 65535) ? cnt16 : cnt16 + 1;
      cnt2 = (cnt2 == 3) ? cnt2 : cnt2 + 1;
    end
    #1;
    check_regs();
  endtask

  task automatic model_reset();
    m = '0; cnt16 = 0; cnt2 = 0;
  endtask

  initial begin
    model_reset();
    cur = '0;
    tbl[0] = '{mk(1, 5, 6, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0), 0, 2'b00, 2'b00};
    tbl[1] = '{mk(1, 1, 7, 1, 1, 11, 1, 0, 0, 5, 1, 5, 1), 0, 2'b01, 2'b00};
    tbl[2] = '{mk(1, 0, 0, 1, 1, 12, 1, 0, 0, 3, 1, 7, 1), 0, 2'b00, 2'b10};
    tbl[3] = '{mk(1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 1, 0, 1), 0, 2'b00, 2'b00};
    tbl[4] = '{mk(1, 3, 9, 1, 1, 13, 1, 0, 0, 2, 1, 0, 0), 1, 2'b01, 2'b00};
    tbl[5] = '{tbl[4].inp, 0, 2'b00, 2'b00};
    tbl[6] = '{mk(1, 4, 0, 1, 0, 9, 1, 1, 0, 9, 1, 0, 0), 0, 2'b00, 2'b01};
    tbl[7] = '{mk(1, 1, 9, 0, 1, 14, 1, 0, 1, 0, 0, 0, 0), 0, 2'b00, 2'b00};
    tbl[8] = '{mk(0, 9, 9, 1, 1, 15, 1, 1, 0, 0, 0, 0, 0), 0, 2'b00, 2'b00};
    sat_exp = '{1, 2, 3, 3, 3};

    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check_comb();
    rst = 0;

    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].inp);
      chk($sformatf("tbl%0d_stall", k), 64'(stall), 64'(tbl[k].stall));
      chk($sformatf("tbl%0d_fwd_a", k), 64'({fwd_a_sel1, fwd_a_sel2}), 64'(tbl[k].a));
      chk($sformatf("tbl%0d_fwd_b", k), 64'({fwd_b_sel1, fwd_b_sel2}), 64'(tbl[k].b));
      edge_step();
    end

    for (int k = 0; k < 400; k++) begin
      in_t r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom));
      drive(r);
      check_comb();
      edge_step();
    end

    // Asynchronous reset while a load-use stall is being asserted.
    drive(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0));
    edge_step();
    drive(mk(1, 9, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0));
    check_comb();
    chk("pre_reset_stall", 64'(stall), 64'(1));
    rst = 1;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    chk("rst_ex_reg_write", 64'(ex_reg_write), 64'(0));
    chk("rst_ex_mem_read", 64'(ex_mem_read), 64'(0));
    chk("rst_ex_rd", 64'(ex_rd), 64'(0));
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_fwd", 64'({fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2}), 64'(0));
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
    #1;
    rst = 0;
    model_reset();

    // Five load-use episodes: narrow counter must read 1,2,3,3,3.
    for (int k = 0; k < 5; k++) begin
      drive(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0));
      edge_step();
      drive(mk(1, 0, 9, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0));
      check_comb();
      edge_step();
      chk($sformatf("sat_cnt%0d", k), 64'(s_cnt), 64'(sat_exp[k]));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
